// File: rtl/uart_pkg.sv
// uart_pkg: shared UART state encoding and baud-rate helpers.
// Used by both the receive frame logic and the transmit-side baud generator.
package uart_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } state_t;

  function automatic int calc_bps_cnt(input int clk_freq, input int baud);
    return clk_freq / baud;
  endfunction

  function automatic int calc_bps_half(input int clk_freq, input int baud);
    return calc_bps_cnt(clk_freq, baud) / 2;
  endfunction

endpackage

// File: rtl/uart_bps_cnt.sv
// uart_bps_cnt: per-bit clock counter, held at zero while idle, strobes at mid-bit.
module uart_bps_cnt #(
  parameter int BPS_CNT  = 5208,
  parameter int BPS_HALF = 2604
) (
  input  logic clk,
  input  logic rst_n,
  input  logic run,
  output logic sample
);
  localparam int W = $clog2(BPS_CNT);

  logic [W-1:0] cnt_q, cnt_d;

  always_comb cnt_d = !run ? '0 : (cnt_q == W'(BPS_CNT - 1)) ? '0 : cnt_q + 1'b1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

  assign sample = (cnt_q == W'(BPS_HALF));

endmodule

// File: rtl/uart_rx_frame.sv
// uart_rx_frame: 8N1 UART receiver with mid-bit sampling, done and framing-error strobes.
module uart_rx_frame
  import uart_pkg::*;
#(
  parameter int CLK_FREQ = 50_000_000,
  parameter int BAUD     = 9600
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       rs232_rx,
  output logic [7:0] rx_data,
  output logic       rx_int,
  output logic       rx_done,
  output logic       frame_err
);
  localparam int BPS_CNT  = calc_bps_cnt(CLK_FREQ, BAUD);
  localparam int BPS_HALF = calc_bps_half(CLK_FREQ, BAUD);

  state_t      state_q;
  logic        s1_q, s2_q, s3_q;
  logic [7:0]  shift_q, data_q;
  logic [2:0]  bit_q;
  logic        int_q, done_q, err_q;
  logic        sample, fall;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_q <= 1'b1;
      s2_q <= 1'b1;
      s3_q <= 1'b1;
    end else begin
      s1_q <= rs232_rx;
      s2_q <= s1_q;
      s3_q <= s2_q;
    end
  end

  assign fall = s3_q & ~s2_q;

  uart_bps_cnt #(
    .BPS_CNT (BPS_CNT),
    .BPS_HALF(BPS_HALF)
  ) u_bps (
    .clk   (clk),
    .rst_n (rst_n),
    .run   (state_q != IDLE),
    .sample(sample)
  );

  // Stop is sampled at mid-bit so IDLE is reached in time for a back-to-back start edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      shift_q <= '0;
      data_q  <= '0;
      bit_q   <= '0;
      int_q   <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      done_q <= 1'b0;
      err_q  <= 1'b0;
      case (state_q)
        IDLE: if (fall) begin
          state_q <= START;
          int_q   <= 1'b1;
        end
        START: if (sample) begin
          if (s2_q) begin
            state_q <= IDLE;
            int_q   <= 1'b0;
          end else begin
            state_q <= DATA;
            bit_q   <= '0;
          end
        end
        DATA: if (sample) begin
          shift_q <= {s2_q, shift_q[7:1]};
          bit_q   <= bit_q + 3'd1;
          if (bit_q == 3'd7) state_q <= STOP;
        end
        STOP: if (sample) begin
          state_q <= IDLE;
          int_q   <= 1'b0;
          if (s2_q) begin
            data_q <= shift_q;
            done_q <= 1'b1;
          end else begin
            err_q  <= 1'b1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign rx_data   = data_q;
  assign rx_int    = int_q;
  assign rx_done   = done_q;
  assign frame_err = err_q;

endmodule
